// File: rtl/multi_pwm_pkg.sv
// Shared register map, CTRL bit positions and counter direction type for the
// multi-channel PWM block.
package multi_pwm_pkg;

   localparam logic [4:0] ADDR_CTRL     = 5'd0;
   localparam logic [4:0] ADDR_PERIOD   = 5'd1;
   localparam logic [4:0] ADDR_PRESCALE = 5'd2;
   localparam logic [4:0] ADDR_STATUS   = 5'd3;
   localparam logic [4:0] ADDR_DUTY0    = 5'd4;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_CENTER = 1;
   localparam int CTRL_POL    = 2;
   localparam int CTRL_IRQ_EN = 3;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler, up or up/down counter, period-boundary strobe and the shadowed
// period and alignment mode shared by all PWM channels.
module pwm_timebase
   import multi_pwm_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int PRE_W = 16
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic             en,
   input  logic             center_src,
   input  logic [CNT_W-1:0] period_src,
   input  logic [PRE_W-1:0] prescale,
   output logic [CNT_W-1:0] cnt,
   output logic             load,
   output logic             boundary
);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_s_q, period_s_d;
   dir_t             dir_q, dir_d;
   logic             center_s_q, center_s_d;
   logic             first_q, first_d;
   logic             tick;

   // NOTE: every output of this block gets a default first so no path leaves
   // a signal unassigned and infers a latch.
   always_comb begin
      tick     = en && (pre_q >= prescale);
      pre_d    = pre_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      first_d  = first_q;
      boundary = 1'b0;
      if (!en) begin
         pre_d   = '0;
         cnt_d   = '0;
         dir_d   = UP;
         first_d = 1'b1;
      end else begin
         pre_d = tick ? '0 : pre_q + 1'b1;
         if (tick) begin
            first_d = 1'b0;
            if (!center_s_q) begin
               boundary = (cnt_q == period_s_q);
               cnt_d    = boundary ? '0 : cnt_q + 1'b1;
               dir_d    = UP;
            end else begin
               // The first tick after enable opens a fresh center-aligned cycle.
               boundary = first_q || (period_s_q == '0) || (cnt_q == '0 && dir_q == DOWN);
               if (period_s_q == '0) begin
                  cnt_d = '0;
                  dir_d = UP;
               end else if (dir_q == UP) begin
                  if (cnt_q >= period_s_q) begin
                     cnt_d = cnt_q - 1'b1;
                     dir_d = DOWN;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (cnt_q == '0) begin
                  cnt_d = cnt_q + 1'b1;
                  dir_d = UP;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
      end
      load       = !en || boundary;
      period_s_d = load ? period_src : period_s_q;
      center_s_d = load ? center_src : center_s_q;
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         pre_q      <= '0;
         cnt_q      <= '0;
         period_s_q <= '0;
         dir_q      <= UP;
         center_s_q <= 1'b0;
         first_q    <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         cnt_q      <= cnt_d;
         period_s_q <= period_s_d;
         dir_q      <= dir_d;
         center_s_q <= center_s_d;
         first_q    <= first_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/multi_pwm_avalon.sv
// N-channel PWM with Avalon-MM register file, shadowed duty cycles, output
// polarity and a level period-end interrupt.
module multi_pwm_avalon
   import multi_pwm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int PRE_W  = 16
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [4:0]        avs_address,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   output logic              irq,
   output logic [NUM_CH-1:0] pwm_out
);

   logic [3:0]        ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [PRE_W-1:0]  prescale_q, prescale_d;
   logic              pflag_q, pflag_d;
   logic              irq_q, irq_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic [NUM_CH-1:0] raw;
   logic [CNT_W-1:0]  duty_q   [NUM_CH];
   logic [CNT_W-1:0]  duty_d   [NUM_CH];
   logic [CNT_W-1:0]  duty_s_q [NUM_CH];
   logic [CNT_W-1:0]  duty_s_d [NUM_CH];
   logic [CNT_W-1:0]  cnt;
   logic              shadow_load, boundary, en;
   logic              center_src;
   logic [CNT_W-1:0]  period_src;
   logic              unused_wdata;

   assign en           = ctrl_q[CTRL_EN];
   assign unused_wdata = ^avs_writedata;

   // While disabled the shadows follow the registers including this cycle's write,
   // so the mode and period written together with EN apply from the first tick.
   assign center_src = en ? ctrl_q[CTRL_CENTER] : ctrl_d[CTRL_CENTER];
   assign period_src = en ? period_q : period_d;

   pwm_timebase #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
   ) u_timebase (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .en            (en),
      .center_src    (center_src),
      .period_src    (period_src),
      .prescale      (prescale_q),
      .cnt           (cnt),
      .load          (shadow_load),
      .boundary      (boundary)
   );

   always_comb begin
      ctrl_d     = ctrl_q;
      period_d   = period_q;
      prescale_d = prescale_q;
      pflag_d    = pflag_q;
      rdata_d    = rdata_q;
      if (avs_write) begin
         case (avs_address)
            ADDR_CTRL:     ctrl_d     = avs_writedata[3:0];
            ADDR_PERIOD:   period_d   = avs_writedata[CNT_W-1:0];
            ADDR_PRESCALE: prescale_d = avs_writedata[PRE_W-1:0];
            ADDR_STATUS:   if (avs_writedata[0]) pflag_d = 1'b0;
            default:       ;
         endcase
      end
      // A boundary wins over a write-1-clear in the same cycle.
      if (boundary) pflag_d = 1'b1;
      irq_d = pflag_q & ctrl_q[CTRL_IRQ_EN];

      for (int i = 0; i < NUM_CH; i++) begin
         duty_d[i] = duty_q[i];
         if (avs_write && avs_address == ADDR_DUTY0 + 5'(i)) duty_d[i] = avs_writedata[CNT_W-1:0];
         duty_s_d[i] = shadow_load ? (en ? duty_q[i] : duty_d[i]) : duty_s_q[i];
         raw[i]      = cnt < duty_s_q[i];
         pwm_d[i]    = en ? (raw[i] ^ ctrl_q[CTRL_POL]) : ctrl_q[CTRL_POL];
      end

      if (avs_read) begin
         rdata_d = '0;
         case (avs_address)
            ADDR_CTRL:     rdata_d[3:0]       = ctrl_q;
            ADDR_PERIOD:   rdata_d[CNT_W-1:0] = period_q;
            ADDR_PRESCALE: rdata_d[PRE_W-1:0] = prescale_q;
            ADDR_STATUS:   rdata_d[0]         = pflag_q;
            default: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (avs_address == ADDR_DUTY0 + 5'(i)) rdata_d[CNT_W-1:0] = duty_q[i];
               end
            end
         endcase
      end
   end

   // NOTE: the duty arrays are reset element by element because software expects
   // every register and shadow to read back 0 after reset.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         ctrl_q     <= '0;
         period_q   <= '0;
         prescale_q <= '0;
         pflag_q    <= 1'b0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
         pwm_q      <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_q[i]   <= '0;
            duty_s_q[i] <= '0;
         end
      end else begin
         ctrl_q     <= ctrl_d;
         period_q   <= period_d;
         prescale_q <= prescale_d;
         pflag_q    <= pflag_d;
         irq_q      <= irq_d;
         rdata_q    <= rdata_d;
         pwm_q      <= pwm_d;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_q[i]   <= duty_d[i];
            duty_s_q[i] <= duty_s_d[i];
         end
      end
   end

   assign avs_readdata = rdata_q;
   assign irq          = irq_q;
   assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_multi_pwm_avalon.sv
// Directed bench for multi_pwm_avalon: inputs change and outputs are sampled
// on the falling edge, k counts rising edges since the enabling CTRL write.
module tb_multi_pwm_avalon;
   import multi_pwm_pkg::*;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n = 1'b0;
   logic [4:0]  avs_address = '0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic        avs_read = 1'b0;
   logic [31:0] avs_readdata;
   logic        irq;
   logic [3:0]  pwm_out;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rdat;
   logic [3:0]  e;
   logic [16:1] irq_exp;

   multi_pwm_avalon #(.NUM_CH(4), .CNT_W(16), .PRE_W(16)) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .irq           (irq),
      .pwm_out       (pwm_out)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk_clk);
      avs_write     = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk_clk);
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   // Center-mode counter value at tick step s: 0,1,2,3,4,3,2,1 for PERIOD=4.
   function automatic int tri_val(input int s);
      return (s <= 4) ? s : 8 - s;
   endfunction

   initial begin
      // 1. reset state
      repeat (3) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      repeat (2) @(negedge clk_clk);
      check("reset pwm", 32'(pwm_out), 32'h0);
      check("reset irq", 32'(irq), 32'h0);
      check("reset rdata", avs_readdata, 32'h0);
      for (int a = 0; a < 8; a++) begin
         rd(5'(a), rdat);
         check($sformatf("reset read %0d", a), rdat, 32'h0);
      end
      rd(5'd31, rdat);
      check("reset read 31", rdat, 32'h0);

      // 2. edge mode, period 10 clks, duty 3 / 0 / 15
      wr(ADDR_PERIOD, 32'hFFFF_0009);
      wr(ADDR_PRESCALE, 32'd0);
      wr(ADDR_DUTY0, 32'd3);
      wr(ADDR_DUTY0 + 5'd1, 32'd0);
      wr(ADDR_DUTY0 + 5'd2, 32'd15);
      wr(ADDR_CTRL, 32'h1);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_clk);
         e = {1'b0, 1'b1, 1'b0, 1'(((k - 1) % 10) < 3)};
         check($sformatf("edge pwm k=%0d", k), 32'(pwm_out), 32'(e));
      end
      rd(ADDR_PERIOD, rdat);
      check("period readback masked", rdat, 32'd9);
      rd(ADDR_DUTY0 + 5'd2, rdat);
      check("duty2 readback", rdat, 32'd15);
      wr(5'd25, 32'hFFFF_FFFF);
      rd(5'd25, rdat);
      check("unmapped read", rdat, 32'h0);

      // 3. center mode with prescale 1: 2 clks per count step
      wr(ADDR_CTRL, 32'h0);
      wr(ADDR_PERIOD, 32'd4);
      wr(ADDR_PRESCALE, 32'd1);
      wr(ADDR_DUTY0, 32'd2);
      wr(ADDR_CTRL, 32'h3);
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk_clk);
         check($sformatf("center pwm0 k=%0d", k), 32'(pwm_out[0]),
               32'(tri_val(((k - 1) / 2) % 8) < 2));
      end
      rd(ADDR_CTRL, rdat);
      check("ctrl readback", rdat, 32'h3);

      // 4. duty write mid-period lands at the next boundary; then polarity
      wr(ADDR_CTRL, 32'h0);
      wr(ADDR_PERIOD, 32'd9);
      wr(ADDR_PRESCALE, 32'd0);
      wr(ADDR_DUTY0, 32'd3);
      wr(ADDR_CTRL, 32'h1);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk_clk);
         check($sformatf("shadow pwm0 k=%0d", k), 32'(pwm_out[0]),
               32'(((k - 1) % 10) < ((k <= 10) ? 3 : 6)));
         if (k == 4) begin
            avs_address   = ADDR_DUTY0;
            avs_writedata = 32'd6;
            avs_write     = 1'b1;
         end
         if (k == 5) avs_write = 1'b0;
      end
      wr(ADDR_CTRL, 32'h5);
      check("pol not yet", 32'(pwm_out[3:1]), 32'b010);
      @(negedge clk_clk);
      check("pol applied", 32'(pwm_out[3:1]), 32'b101);

      // 5. interrupt, period 4 clks, clears at k=6,14 and one coinciding with boundary at k=12
      wr(ADDR_CTRL, 32'h0);
      wr(ADDR_PERIOD, 32'd3);
      wr(ADDR_STATUS, 32'h1);
      wr(ADDR_CTRL, 32'h9);
      irq_exp = 16'b0011_1111_0011_0000;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk_clk);
         check($sformatf("irq k=%0d", k), 32'(irq), 32'(irq_exp[k]));
         if (k == 5 || k == 11 || k == 13) begin
            avs_address   = ADDR_STATUS;
            avs_writedata = 32'h1;
            avs_write     = 1'b1;
         end
         if (k == 6 || k == 12 || k == 14) avs_write = 1'b0;
      end
      rd(ADDR_STATUS, rdat);
      check("status pflag", rdat, 32'h1);

      // 6. disable mid-pulse, polarity while idle, re-enable, reset mid-pulse
      wr(ADDR_CTRL, 32'h0);
      check("disable pwm same clk", 32'(pwm_out), 32'b0101);
      @(negedge clk_clk);
      check("disable pwm next clk", 32'(pwm_out), 32'b0000);
      check("disable irq", 32'(irq), 32'h0);
      wr(ADDR_CTRL, 32'h4);
      @(negedge clk_clk);
      check("idle pol level", 32'(pwm_out), 32'b1111);
      wr(ADDR_STATUS, 32'h1);
      wr(ADDR_DUTY0, 32'd2);
      wr(ADDR_CTRL, 32'h9);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk_clk);
         e = {1'b0, 1'b1, 1'b0, 1'(((k - 1) % 4) < 2)};
         check($sformatf("restart pwm k=%0d", k), 32'(pwm_out), 32'(e));
         check($sformatf("restart irq k=%0d", k), 32'(irq), 32'(k >= 5));
      end
      check("rdata held", avs_readdata, 32'h1);
      reset_reset_n = 1'b0;
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      check("mid reset pwm", 32'(pwm_out), 32'h0);
      check("mid reset irq", 32'(irq), 32'h0);
      check("mid reset rdata", avs_readdata, 32'h0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk_clk);
         check($sformatf("post reset pwm k=%0d", k), 32'(pwm_out), 32'h0);
         check($sformatf("post reset irq k=%0d", k), 32'(irq), 32'h0);
      end
      for (int a = 0; a < 7; a++) begin
         rd(5'(a), rdat);
         check($sformatf("post reset read %0d", a), rdat, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
